// File: rtl/fpu_exec_ctrl.sv
// FP issue/writeback controller: owns the FP register file and the cc flag,
// latches one instruction's operands, holds them on the FPU for a fixed
// latency, then writes the result back to fd (or to cc for compares).
module fpu_exec_ctrl #(
    parameter int unsigned FPU_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [2:0]  issue_op,
    input  logic [4:0]  issue_fd,
    input  logic [4:0]  issue_fs,
    input  logic [4:0]  issue_ft,
    output logic        done,
    output logic        busy,
    input  logic        mtc1_we,
    input  logic [4:0]  mtc1_addr,
    input  logic [31:0] mtc1_data,
    input  logic [4:0]  mfc1_addr,
    output logic [31:0] mfc1_data,
    output logic        cc,
    output logic [31:0] fpu_in1,
    output logic [31:0] fpu_in2,
    output logic [2:0]  fpu_op,
    input  logic [31:0] fpu_result
);

    localparam logic [2:0] ADD = 3'h0;
    localparam logic [2:0] SUB = 3'h1;
    localparam logic [2:0] EQ  = 3'h2;
    localparam logic [2:0] LT  = 3'h3;
    localparam logic [2:0] GT  = 3'h4;
    localparam logic [2:0] LE  = 3'h5;
    localparam logic [2:0] GE  = 3'h6;
    localparam logic [2:0] MOV = 3'h7;

    localparam logic [3:0] CntLoad = 4'(FPU_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  fd_q, fd_d;
    logic        wr_q, wr_d;       // 1: result goes to R[fd]; 0: result goes to cc
    logic        done_q, done_d;
    logic        cc_q, cc_d;
    logic [31:0] in1_q, in1_d;
    logic [31:0] in2_q, in2_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        issue_is_cmp;

    assign issue_is_cmp = (issue_op == EQ) || (issue_op == LT) || (issue_op == GT) ||
                          (issue_op == LE) || (issue_op == GE);

    assign issue_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign cc          = cc_q;
    assign fpu_in1     = in1_q;
    assign fpu_in2     = in2_q;
    assign fpu_op      = op_q;
    // Pre-edge read: a same-cycle mtc1 is not forwarded.
    assign mfc1_data   = regs_q[mfc1_addr];

    // Next-state: FSM sequencing, operand capture, writeback and mtc1 writes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fd_d    = fd_q;
        wr_d    = wr_q;
        done_d  = 1'b0;
        cc_d    = cc_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        op_d    = op_q;
        regs_d  = regs_q;

        unique case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    // Same-cycle mtc1 to a source is earlier in program order.
                    in1_d   = (mtc1_we && mtc1_addr == issue_fs) ? mtc1_data : regs_q[issue_fs];
                    in2_d   = (mtc1_we && mtc1_addr == issue_ft) ? mtc1_data : regs_q[issue_ft];
                    op_d    = issue_op;
                    fd_d    = issue_fd;
                    wr_d    = !issue_is_cmp;
                    cnt_d   = CntLoad;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = WB;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WB: begin
                state_d = IDLE;
                if (wr_q) begin
                    regs_d[fd_q] = fpu_result;
                end else begin
                    cc_d = fpu_result[0];
                end
            end
            default: state_d = IDLE;
        endcase

        // Applied last so an mtc1 to fd during WB overrides the FPU result.
        if (mtc1_we) begin
            regs_d[mtc1_addr] = mtc1_data;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            fd_q    <= 5'd0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            cc_q    <= 1'b0;
            in1_q   <= 32'd0;
            in2_q   <= 32'd0;
            op_q    <= ADD;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fd_q    <= fd_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            cc_q    <= cc_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            op_q    <= op_d;
            regs_q  <= regs_d;
        end
    end

endmodule

// File: tb/tb_fpu_exec_ctrl.sv
// Bench for fpu_exec_ctrl: directed scenarios followed by random instruction
// streams, checked against a transaction-level register-file model.
`timescale 1ns/1ps
module tb_fpu_exec_ctrl;

    localparam int L = 2;

    localparam logic [2:0] ADD = 3'h0;
    localparam logic [2:0] SUB = 3'h1;
    localparam logic [2:0] EQ  = 3'h2;
    localparam logic [2:0] LT  = 3'h3;
    localparam logic [2:0] GT  = 3'h4;
    localparam logic [2:0] LE  = 3'h5;
    localparam logic [2:0] GE  = 3'h6;
    localparam logic [2:0] MOV = 3'h7;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_op;
    logic [4:0]  issue_fd, issue_fs, issue_ft;
    logic        done, busy;
    logic        mtc1_we;
    logic [4:0]  mtc1_addr;
    logic [31:0] mtc1_data;
    logic [4:0]  mfc1_addr;
    logic [31:0] mfc1_data;
    logic        cc;
    logic [31:0] fpu_in1, fpu_in2;
    logic [2:0]  fpu_op;
    logic [31:0] fpu_result;

    // Bench FPU: integer stand-in (order matches FP order for positive values);
    // use_fixed lets a directed test supply an exact IEEE result.
    logic        use_fixed;
    logic [31:0] fixed_res;

    logic [31:0] m_r [32];
    logic        m_cc;
    int          n_cmp;
    int          n_err;

    function automatic logic [31:0] fake_fpu(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            EQ:      return {31'd0, a == b};
            LT:      return {31'd0, a < b};
            GT:      return {31'd0, a > b};
            LE:      return {31'd0, a <= b};
            GE:      return {31'd0, a >= b};
            default: return a;
        endcase
    endfunction

    function automatic logic writes_reg(input logic [2:0] op);
        return (op == ADD) || (op == SUB) || (op == MOV);
    endfunction

    assign fpu_result = use_fixed ? fixed_res : fake_fpu(fpu_op, fpu_in1, fpu_in2);

    fpu_exec_ctrl #(.FPU_LATENCY(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_op   (issue_op),
        .issue_fd   (issue_fd),
        .issue_fs   (issue_fs),
        .issue_ft   (issue_ft),
        .done       (done),
        .busy       (busy),
        .mtc1_we    (mtc1_we),
        .mtc1_addr  (mtc1_addr),
        .mtc1_data  (mtc1_data),
        .mfc1_addr  (mfc1_addr),
        .mfc1_data  (mfc1_data),
        .cc         (cc),
        .fpu_in1    (fpu_in1),
        .fpu_in2    (fpu_in2),
        .fpu_op     (fpu_op),
        .fpu_result (fpu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reads all 32 registers while idle; realigns to post-edge afterwards.
    task automatic check_regs(input string tag);
        issue_valid = 1'b0;
        mtc1_we     = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mfc1_addr = 5'(i);
            #1;
            chk($sformatf("%s_R%0d", tag, i), mfc1_data, m_r[i]);
        end
        tick();
    endtask

    task automatic mtc1_write(input logic [4:0] a, input logic [31:0] d);
        mtc1_we   = 1'b1;
        mtc1_addr = a;
        mtc1_data = d;
        tick();
        m_r[a]  = d;
        mtc1_we = 1'b0;
    endtask

    // One full instruction: accept, L exec cycles, writeback.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [4:0] fd,
                         input logic [4:0] fs, input logic [4:0] ft,
                         input logic b_we, input logic [4:0] b_addr, input logic [31:0] b_data,
                         input logic w_we, input logic [4:0] w_addr, input logic [31:0] w_data,
                         input logic rnd);
        logic [31:0] e1, e2, res;
        logic        x_we;
        logic [4:0]  x_addr;
        logic [31:0] x_data;
        e1 = (b_we && b_addr == fs) ? b_data : m_r[fs];
        e2 = (b_we && b_addr == ft) ? b_data : m_r[ft];
        chk({tag, "_ready_idle"}, issue_ready, 1'b1);
        chk({tag, "_busy_idle"}, busy, 1'b0);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_fd    = fd;
        issue_fs    = fs;
        issue_ft    = ft;
        mtc1_we     = b_we;
        mtc1_addr   = b_addr;
        mtc1_data   = b_data;
        tick();
        if (b_we) m_r[b_addr] = b_data;
        mtc1_we = 1'b0;
        for (int k = 0; k < L; k++) begin
            // Garbage issue requests while busy must be ignored.
            issue_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            issue_op    = 3'($urandom_range(0, 7));
            issue_fs    = 5'($urandom);
            issue_ft    = 5'($urandom);
            issue_fd    = 5'($urandom);
            x_we   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            x_addr = rnd ? fs : 5'd0;
            if ($urandom_range(0, 1) == 1) x_addr = 5'($urandom);
            x_data = $urandom;
            mtc1_we   = x_we;
            mtc1_addr = x_addr;
            mtc1_data = x_data;
            #1;
            chk({tag, "_ready_exec"}, issue_ready, 1'b0);
            chk({tag, "_busy_exec"}, busy, 1'b1);
            chk({tag, "_done_exec"}, done, 1'b0);
            chk({tag, "_in1"}, fpu_in1, e1);
            chk({tag, "_in2"}, fpu_in2, e2);
            chk({tag, "_op"}, fpu_op, op);
            tick();
            if (x_we) m_r[x_addr] = x_data;
        end
        issue_valid = 1'b0;
        mtc1_we     = 1'b0;
        chk({tag, "_done_wb"}, done, 1'b1);
        chk({tag, "_ready_wb"}, issue_ready, 1'b0);
        res = use_fixed ? fixed_res : fake_fpu(op, e1, e2);
        mtc1_we   = w_we;
        mtc1_addr = w_addr;
        mtc1_data = w_data;
        tick();
        if (writes_reg(op)) m_r[fd] = res;
        else m_cc = res[0];
        if (w_we) m_r[w_addr] = w_data;
        mtc1_we = 1'b0;
        chk({tag, "_done_after"}, done, 1'b0);
        chk({tag, "_ready_after"}, issue_ready, 1'b1);
        chk({tag, "_cc"}, cc, m_cc);
        mfc1_addr = fd;
        #1;
        chk({tag, "_rd_fd"}, mfc1_data, m_r[fd]);
    endtask

    initial begin
        logic [4:0]  ra;
        logic [31:0] rd;
        n_cmp = 0;
        n_err = 0;
        use_fixed = 1'b0;
        fixed_res = 32'd0;
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_op = 3'd0;
        issue_fd = 5'd0;
        issue_fs = 5'd0;
        issue_ft = 5'd0;
        mtc1_we = 1'b0;
        mtc1_addr = 5'd0;
        mtc1_data = 32'd0;
        mfc1_addr = 5'd0;
        for (int i = 0; i < 32; i++) m_r[i] = 32'd0;
        m_cc = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", issue_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_cc", cc, 1'b0);
        chk("rst_fpu_op", fpu_op, ADD);
        chk("rst_in1", fpu_in1, 32'd0);
        check_regs("rst");

        // ADD 1.0 + 2.0 = 3.0
        mtc1_write(5'd1, 32'h3F80_0000);
        mtc1_write(5'd2, 32'h4000_0000);
        use_fixed = 1'b1;
        fixed_res = 32'h4040_0000;
        do_op("add", ADD, 5'd3, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        use_fixed = 1'b0;
        chk("add_R3", m_r[3], 32'h4040_0000);
        tick();

        // Compares: LT sets cc, GE clears it, no register writes
        do_op("lt", LT, 5'd9, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("lt_cc1", cc, 1'b1);
        do_op("ge", GE, 5'd9, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("ge_cc0", cc, 1'b0);
        check_regs("cmp");

        // Bypass of a same-cycle mtc1 into the latched operand
        do_op("byp", MOV, 5'd5, 5'd4, 5'd0, 1'b1, 5'd4, 32'hC000_0000, 1'b0, 5'd0, 32'd0,
              1'b0);
        mfc1_addr = 5'd5;
        #1;
        chk("byp_R5", mfc1_data, 32'hC000_0000);
        tick();

        // mtc1 to fd during WB wins over the FPU result
        do_op("wbc", ADD, 5'd6, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h1234_5678,
              1'b0);
        mfc1_addr = 5'd6;
        #1;
        chk("wbc_R6", mfc1_data, 32'h1234_5678);
        tick();

        // Reset during EXEC abandons the instruction
        mtc1_write(5'd7, 32'hDEAD_BEEF);
        issue_valid = 1'b1;
        issue_op    = ADD;
        issue_fd    = 5'd7;
        issue_fs    = 5'd1;
        issue_ft    = 5'd2;
        tick();
        issue_valid = 1'b0;
        chk("rexec_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_r[i] = 32'd0;
        m_cc = 1'b0;
        chk("rexec_idle", busy, 1'b0);
        chk("rexec_ready", issue_ready, 1'b1);
        for (int i = 0; i < L + 2; i++) begin
            chk("rexec_nodone", done, 1'b0);
            tick();
        end
        check_regs("rexec");

        // Random instruction stream with interleaved mtc1/mfc1 traffic
        for (int n = 0; n < 60; n++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                ra = 5'($urandom);
                rd = $urandom;
                mtc1_we   = 1'($urandom_range(0, 1));
                mtc1_addr = ra;
                mtc1_data = rd;
                mfc1_addr = ($urandom_range(0, 1) == 1) ? ra : 5'($urandom);
                #1;
                chk("rnd_mfc1", mfc1_data, m_r[mfc1_addr]);
                tick();
                if (mtc1_we) m_r[ra] = rd;
                mtc1_we = 1'b0;
            end
            do_op("rnd", 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom), $urandom, 1'b1);
            tick();
        end
        check_regs("rnd_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
